// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//
// Shares the single synchronous data-memory port between two bus masters
// (master 0: core LSU, master 1: DMA/debug). Exactly one transaction is in
// flight at a time. Each accepted command is presented to memory for one
// cycle, and read data comes back with a one-cycle rvalid pulse after a fixed
// memory latency.
//
// Parameters
//   MEM_LATENCY  cycles from the memory request cycle to valid mem_rdata_i (1..15)
//   FIXED_PRIO   0: round-robin between contending masters, 1: master 0 always wins
//
// Ports
//   clk_i, arstn_i                     clock, asynchronous active-low reset
//   mN_req_i/we_i/be_i/adr_i/wdata_i   master N command (N = 0, 1); req held until gnt
//   mN_gnt_o                           command accepted at this clock edge
//   mN_rvalid_o, mN_rdata_o            completion pulse and read data (0 for writes)
//   mem_req_o/we_o/be_o/adr_o/wdata_o  memory command
//   mem_rdata_i                        memory read data
//   busy_o                             transaction in progress (not idle)

module data_mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic        clk_i,
    input  logic        arstn_i,

    input  logic        m0_req_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_adr_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,

    input  logic        m1_req_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_adr_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_adr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StResp
    } state_e;

    // WAIT lasts counter+1 cycles, so loading LATENCY-2 yields LATENCY-1 wait cycles.
    localparam logic [3:0] WaitLoad = (MEM_LATENCY > 1) ? 4'(MEM_LATENCY - 2) : 4'd0;
    localparam logic       UseWait  = (MEM_LATENCY > 1);
    localparam logic       FixPrio  = (FIXED_PRIO != 0);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;

    // Registered command of the transaction in flight.
    logic        cmd_we_q;
    logic [3:0]  cmd_be_q;
    logic [31:0] cmd_adr_q;
    logic [31:0] cmd_wdata_q;
    logic        owner_q;   // 1: master 1 owns the transaction

    // Master granted most recently; reset to 1 so master 0 wins the first contest.
    logic        last_q;

    logic        any_req;
    logic        win;       // 1: master 1 wins arbitration this cycle
    logic        grant_en;
    logic        in_issue;
    logic        in_resp;
    logic [31:0] resp_data;

    // ------------------------------------------------------------------
    // Arbitration (only meaningful while idle)
    // ------------------------------------------------------------------
    always_comb begin
        any_req = m0_req_i | m1_req_i;
        win     = 1'b0;
        if (m0_req_i && m1_req_i) begin
            win = FixPrio ? 1'b0 : ~last_q;
        end else begin
            win = m1_req_i;
        end
        grant_en = (state_q == StIdle) && any_req;
    end

    // Grants are gated by reset so every output is 0 while reset is held.
    assign m0_gnt_o = grant_en & ~win & arstn_i;
    assign m1_gnt_o = grant_en &  win & arstn_i;

    // ------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (UseWait) begin
                    state_d = StWait;
                    cnt_d   = WaitLoad;
                end else begin
                    state_d = StResp;
                end
            end
            StWait: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Command capture at the grant edge
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            cmd_we_q    <= 1'b0;
            cmd_be_q    <= 4'h0;
            cmd_adr_q   <= 32'h0;
            cmd_wdata_q <= 32'h0;
            owner_q     <= 1'b0;
            last_q      <= 1'b1;
        end else if (grant_en) begin
            cmd_we_q    <= win ? m1_we_i    : m0_we_i;
            cmd_be_q    <= win ? m1_be_i    : m0_be_i;
            cmd_adr_q   <= win ? m1_adr_i   : m0_adr_i;
            cmd_wdata_q <= win ? m1_wdata_i : m0_wdata_i;
            owner_q     <= win;
            last_q      <= win;
        end
    end

    // ------------------------------------------------------------------
    // Memory side and response outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_issue = (state_q == StIssue);
        in_resp  = (state_q == StResp);

        mem_req_o   = in_issue;
        mem_we_o    = in_issue & cmd_we_q;
        mem_be_o    = in_issue ? cmd_be_q : 4'h0;
        // Address and write data simply hold the last captured command.
        mem_adr_o   = cmd_adr_q;
        mem_wdata_o = cmd_wdata_q;

        resp_data   = (in_resp && !cmd_we_q) ? mem_rdata_i : 32'h0;

        m0_rvalid_o = in_resp & ~owner_q;
        m1_rvalid_o = in_resp &  owner_q;
        m0_rdata_o  = m0_rvalid_o ? resp_data : 32'h0;
        m1_rdata_o  = m1_rvalid_o ? resp_data : 32'h0;

        busy_o      = (state_q != StIdle);
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter. Three instances share one set of
// inputs: [0] MEM_LATENCY=1 round-robin, [1] MEM_LATENCY=1 fixed priority,
// [2] MEM_LATENCY=3 round-robin. Each check looks at the instance relevant to it.

module tb_data_mem_arbiter;

    logic        clk;
    logic        arstn;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [3:0]  be;
    logic [31:0] adr0, adr1, wdata, mrd;

    logic        m0_gnt    [3];
    logic        m1_gnt    [3];
    logic        m0_rvalid [3];
    logic        m1_rvalid [3];
    logic [31:0] m0_rdata  [3];
    logic [31:0] m1_rdata  [3];
    logic        mem_req   [3];
    logic        mem_we    [3];
    logic [3:0]  mem_be    [3];
    logic [31:0] mem_adr   [3];
    logic [31:0] mem_wdata [3];
    logic        busy      [3];

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_arbiter #(
            .MEM_LATENCY((g == 2) ? 3 : 1),
            .FIXED_PRIO ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk_i      (clk),
            .arstn_i    (arstn),
            .m0_req_i   (m0_req),
            .m0_we_i    (m0_we),
            .m0_be_i    (be),
            .m0_adr_i   (adr0),
            .m0_wdata_i (wdata),
            .m0_gnt_o   (m0_gnt[g]),
            .m0_rvalid_o(m0_rvalid[g]),
            .m0_rdata_o (m0_rdata[g]),
            .m1_req_i   (m1_req),
            .m1_we_i    (m1_we),
            .m1_be_i    (be),
            .m1_adr_i   (adr1),
            .m1_wdata_i (wdata),
            .m1_gnt_o   (m1_gnt[g]),
            .m1_rvalid_o(m1_rvalid[g]),
            .m1_rdata_o (m1_rdata[g]),
            .mem_req_o  (mem_req[g]),
            .mem_we_o   (mem_we[g]),
            .mem_be_o   (mem_be[g]),
            .mem_adr_o  (mem_adr[g]),
            .mem_wdata_o(mem_wdata[g]),
            .mem_rdata_i(mrd),
            .busy_o     (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] adr0, adr1;
        logic [3:0]  be;
        logic [31:0] wdata, mrd;
        logic [1:0]  e_gnt;   // {m1, m0}
        logic [1:0]  e_rv;    // {m1, m0}
        logic        e_mreq, e_mwe;
        logic [3:0]  e_mbe;
        logic        e_busy;
        logic [31:0] e_adr, e_wd, e_rd0, e_rd1;
    } vec_t;

    localparam int NumVec = 20;
    vec_t vecs [NumVec];

    function automatic logic [138:0] obs(input int k);
        return {m1_gnt[k], m0_gnt[k], m1_rvalid[k], m0_rvalid[k], mem_req[k], mem_we[k],
                mem_be[k], busy[k], mem_adr[k], mem_wdata[k], m0_rdata[k], m1_rdata[k]};
    endfunction

    task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_req = 1'b0; m1_req = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
        be = 4'hF; adr0 = 32'h0; adr1 = 32'h0; wdata = 32'h0; mrd = 32'h0;
    endtask

    // Asserts reset for two edges; releases at posedge+1, away from the edge.
    task automatic do_reset();
        arstn = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        arstn = 1'b1;
    endtask

    initial begin
        // Cycle-by-cycle vectors for instance 0 (latency 1, round-robin).
        vecs[0]  = '{'0, '0, '0, '0, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '0, '0, 4'h0, '0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[1]  = '{'1, '0, '0, '0, 32'h10, 32'h0, 4'hF, 32'h0, 32'h0,
                     2'b01, 2'b00, '0, '0, 4'h0, '0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[2]  = '{'0, '0, '0, '0, 32'h10, 32'h0, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '0, 4'hF, '1, 32'h10, 32'h0, 32'h0, 32'h0};
        vecs[3]  = '{'0, '0, '0, '0, 32'h0, 32'h0, 4'hF, 32'h0, 32'hDEAD_BEEF,
                     2'b00, 2'b01, '0, '0, 4'h0, '1, 32'h10, 32'h0, 32'hDEAD_BEEF, 32'h0};
        vecs[4]  = '{'0, '1, '0, '1, 32'h0, 32'h104, 4'hC, 32'h1234_5678, 32'h0,
                     2'b10, 2'b00, '0, '0, 4'h0, '0, 32'h10, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{'0, '0, '0, '0, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '1, 4'hC, '1, 32'h104, 32'h1234_5678, 32'h0, 32'h0};
        vecs[6]  = '{'0, '0, '0, '0, 32'h0, 32'h0, 4'hF, 32'h0, 32'hFFFF_FFFF,
                     2'b00, 2'b10, '0, '0, 4'h0, '1, 32'h104, 32'h1234_5678, 32'h0, 32'h0};
        vecs[7]  = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b01, 2'b00, '0, '0, 4'h0, '0, 32'h104, 32'h1234_5678, 32'h0, 32'h0};
        vecs[8]  = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '0, 4'hF, '1, 32'h20, 32'h0, 32'h0, 32'h0};
        vecs[9]  = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'hA0A0_A0A0,
                     2'b00, 2'b01, '0, '0, 4'h0, '1, 32'h20, 32'h0, 32'hA0A0_A0A0, 32'h0};
        vecs[10] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b10, 2'b00, '0, '0, 4'h0, '0, 32'h20, 32'h0, 32'h0, 32'h0};
        vecs[11] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '0, 4'hF, '1, 32'h30, 32'h0, 32'h0, 32'h0};
        vecs[12] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h5555_AAAA,
                     2'b00, 2'b10, '0, '0, 4'h0, '1, 32'h30, 32'h0, 32'h0, 32'h5555_AAAA};
        vecs[13] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b01, 2'b00, '0, '0, 4'h0, '0, 32'h30, 32'h0, 32'h0, 32'h0};
        vecs[14] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '0, 4'hF, '1, 32'h20, 32'h0, 32'h0, 32'h0};
        vecs[15] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h1111_2222,
                     2'b00, 2'b01, '0, '0, 4'h0, '1, 32'h20, 32'h0, 32'h1111_2222, 32'h0};
        vecs[16] = '{'1, '1, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b10, 2'b00, '0, '0, 4'h0, '0, 32'h20, 32'h0, 32'h0, 32'h0};
        // Master 0 raises req during ISSUE and withdraws it before IDLE: no grant.
        vecs[17] = '{'1, '0, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '1, '0, 4'hF, '1, 32'h30, 32'h0, 32'h0, 32'h0};
        vecs[18] = '{'0, '0, '0, '0, 32'h20, 32'h30, 4'hF, 32'h0, 32'h3333_4444,
                     2'b00, 2'b10, '0, '0, 4'h0, '1, 32'h30, 32'h0, 32'h0, 32'h3333_4444};
        vecs[19] = '{'0, '0, '0, '0, 32'h0, 32'h0, 4'hF, 32'h0, 32'h0,
                     2'b00, 2'b00, '0, '0, 4'h0, '0, 32'h30, 32'h0, 32'h0, 32'h0};

        // Reset state, with requests high to show grants are held off too.
        arstn = 1'b0;
        idle_inputs();
        m0_req = 1'b1;
        m1_req = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) chk($sformatf("reset_outputs[%0d]", k), obs(k), 139'(0));

        // Table-driven sequence on instance 0.
        do_reset();
        for (int i = 0; i < NumVec; i++) begin
            m0_req = vecs[i].r0;   m1_req = vecs[i].r1;
            m0_we  = vecs[i].we0;  m1_we  = vecs[i].we1;
            adr0   = vecs[i].adr0; adr1   = vecs[i].adr1;
            be     = vecs[i].be;   wdata  = vecs[i].wdata; mrd = vecs[i].mrd;
            @(negedge clk);
            chk($sformatf("vec%0d", i), obs(0),
                {vecs[i].e_gnt, vecs[i].e_rv, vecs[i].e_mreq, vecs[i].e_mwe, vecs[i].e_mbe,
                 vecs[i].e_busy, vecs[i].e_adr, vecs[i].e_wd, vecs[i].e_rd0, vecs[i].e_rd1});
            step();
        end

        // Fixed priority on instance 1: m0 wins three times, m1 only after m0 drops.
        do_reset();
        m0_req = 1'b1; m1_req = 1'b1; adr0 = 32'h20; adr1 = 32'h30;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk($sformatf("fixprio_gnt_c%0d", c), 139'({m1_gnt[1], m0_gnt[1]}),
                139'((c % 3 == 0) ? 2'b01 : 2'b00));
            step();
        end
        m0_req = 1'b0;
        @(negedge clk);
        chk("fixprio_m1_after_drop", 139'({m1_gnt[1], m0_gnt[1]}), 139'(2'b10));
        step();
        m1_req = 1'b0;
        step();
        @(negedge clk);
        chk("fixprio_m1_rvalid", 139'({m1_rvalid[1], m0_rvalid[1]}), 139'(2'b10));
        step();

        // Latency 3 on instance 2: gnt c0, mem_req c1, rvalid c4, idle c5.
        do_reset();
        mrd = 32'hCAFE_F00D;
        adr0 = 32'h40;
        for (int c = 0; c < 6; c++) begin
            logic [3:0] e;
            m0_req = (c == 0);
            e = (c == 0) ? 4'b1000 : (c == 1) ? 4'b0110 : (c == 4) ? 4'b0011 :
                (c == 5) ? 4'b0000 : 4'b0010;
            @(negedge clk);
            chk($sformatf("lat3_ctl_c%0d", c),
                139'({m0_gnt[2], mem_req[2], busy[2], m0_rvalid[2]}), 139'(e));
            chk($sformatf("lat3_rdata_c%0d", c), 139'(m0_rdata[2]),
                139'((c == 4) ? 32'hCAFE_F00D : 32'h0));
            if (c == 1) chk("lat3_adr", 139'(mem_adr[2]), 139'(32'h40));
            step();
        end

        // Reset during ISSUE on instance 0: mem_req drops without a clock edge.
        do_reset();
        m0_req = 1'b1; adr0 = 32'h60;
        step();
        m0_req = 1'b0;
        #2;
        chk("issue_mem_req_before_reset", 139'(mem_req[0]), 139'(1));
        arstn = 1'b0;
        #1;
        chk("issue_async_reset", obs(0), 139'(0));
        step();
        arstn = 1'b1;

        // Reset during WAIT on instance 2 (instances 0/1 are in RESP at that moment).
        do_reset();
        m0_req = 1'b1; adr0 = 32'h50; mrd = 32'h7777_8888;
        step();
        m0_req = 1'b0;
        step();
        #2;
        m0_req = 1'b1; m1_req = 1'b1;
        arstn = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk($sformatf("wait_async_reset[%0d]", k), obs(k), 139'(0));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk($sformatf("in_reset_c%0d", c), obs(2), 139'(0));
            step();
        end
        m0_req = 1'b0; m1_req = 1'b0;
        arstn = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_reset_quiet_c%0d", c),
                139'({m1_rvalid[2], m0_rvalid[2], busy[2]}), 139'(0));
            step();
        end
        m0_req = 1'b1; m1_req = 1'b1;
        @(negedge clk);
        chk("post_reset_contend_lat3", 139'({m1_gnt[2], m0_gnt[2]}), 139'(2'b01));
        chk("post_reset_contend_lat1", 139'({m1_gnt[0], m0_gnt[0]}), 139'(2'b01));
        step();
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
